burst_rom_reader: RTL and testbench
===================================

BURST_ROM_READER -- requirements
Module: burst_rom_reader

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits (legal range 4..32).
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cs  input  1  chip select; low aborts any activity.
REQ-006 read_en  input  1  read request; qualified by cs.
REQ-007 addrb  input  ADDR_W  burst start address, sampled at acceptance.
REQ-008 burst_len  input  4  burst length minus one (0 = 1 word, 15 = 16 words), sampled at acceptance.
REQ-009 ready  input  1  consumer accepts the current word when high with valid.
REQ-010 datab  output  DATA_W  registered read data; all zeros whenever valid is low.
REQ-011 valid  output  1  datab holds a live word.
REQ-012 last  output  1  current word is the final beat of the burst; low when valid low.
REQ-013 busy  output  1  high in BURST state.

Function
REQ-014 The ROM contents SHALL be word(a) = (10*a + 18) mod 2**DATA_W for a in 0..DEPTH-1, fixed at elaboration.
REQ-015 The FSM SHALL have two states, IDLE and BURST.
REQ-016 In IDLE, a rising edge with cs=1 and read_en=1 SHALL accept a request: latch addrb and burst_len, go to BURST, load datab=word(addrb), and set valid=1. last=1 only if burst_len=0.
REQ-017 The first word SHALL be valid exactly one cycle after the acceptance edge. There are no wait states between beats while ready=1.
REQ-018 In BURST, an edge with valid=1 and ready=1 SHALL advance the address by 1, load the next word, and decrement the remaining-beat counter.
REQ-019 On a handshake of the last beat, the block SHALL return to IDLE with valid=0, last=0 and datab=0.
REQ-020 A new request SHALL be accepted no earlier than the edge after the one on which IDLE is re-entered; back-to-back bursts have a one-cycle gap.
REQ-021 While valid=1 and ready=0, datab, last and the address SHALL hold unchanged.
REQ-022 The address SHALL wrap from DEPTH-1 to 0 within a burst.
REQ-023 read_en and addrb changes during BURST SHALL be ignored.
REQ-024 If cs=0 on any edge in BURST, the burst SHALL abort: next state IDLE, valid=0, last=0, datab=0. This takes priority over a ready handshake on the same edge.
REQ-025 busy SHALL equal (state == BURST). While in BURST, valid is always 1.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, datab=0, valid=0, last=0, busy=0, clear the address and beat counter, and clear data_par when present.
REQ-027 Assertion during a burst SHALL discard it; after rst_n rises, the first acceptance is possible at the next rising edge.

Configuration
REQ-028 Macro ROM_PARITY_EN defined: an extra output data_par (1 bit) SHALL be present, registered with datab, equal to the XOR of all datab bits, and 0 whenever valid is low.
REQ-029 Macro ROM_PARITY_EN undefined: data_par SHALL NOT exist, and behaviour is otherwise identical.

Verification (DATA_W=8, ADDR_W=4)
REQ-030 Single read: addrb=3, burst_len=0, ready=1 -> next cycle datab=48, valid=1, last=1; the cycle after, valid=0 and datab=0.
REQ-031 Wrap burst: addrb=14, burst_len=3, ready=1 -> datab 158, 168, 18, 28 on consecutive cycles, last high only on 28, then IDLE.
REQ-032 Backpressure: addrb=0, burst_len=2, ready low for 3 cycles during beat 2 -> datab holds 28 with valid=1 for those cycles, then 38 follows; sequence is 18, 28, 38.
REQ-033 Abort: burst of 8 from addrb=5 with cs dropped after beat 2 (with ready=1 on that edge) -> next cycle valid=0, datab=0, busy=0; a new request afterwards starts cleanly.
REQ-034 Reset mid-burst: rst_n pulsed low during beat 3 -> outputs zero asynchronously; the next request from addrb=1 returns 28.
REQ-035 With ROM_PARITY_EN: addrb=3 (48 = 0x30) -> data_par=0; addrb=1 (28 = 0x1C) -> data_par=1.

Source files
------------

// File: rtl/burst_rom_reader.sv
// burst_rom_reader: burst reader over a fixed on-chip ROM.
// A request (cs & read_en) latches a start address and beat count. One
// registered word is presented per ready handshake, wrapping at the end of
// the ROM. Dropping cs aborts the burst.
// Optional feature: define ROM_PARITY_EN to add the data_par output. It is
// the registered XOR of datab and is zero whenever valid is low.
module burst_rom_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [3:0]        burst_len,
  input  logic              ready,
  output logic [DATA_W-1:0] datab,
  output logic              valid,
  output logic              last,
  output logic              busy
`ifdef ROM_PARITY_EN
  ,
  output logic              data_par
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic [3:0]        beats_left;
  logic [3:0]        beats_left_next;
  logic [DATA_W-1:0] datab_next;
  logic              valid_next;
  logic              last_next;

  // ROM contents are a pure function of the address: (10*a + 18) mod 2**DATA_W.
  // The arithmetic is done at DATA_W width, so the modulo comes from truncation.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(DATA_W'(10) * DATA_W'(a) + DATA_W'(18));
  endfunction

  // State register; reset returns to IDLE at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. In BURST, a low cs wins over a final handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cs && read_en) begin
          state_next = BURST;
        end
      end
      BURST: begin
        if (!cs) begin
          state_next = IDLE;
        end else if (ready && (beats_left == 4'd0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values. Stalls hold, handshakes advance, and leaving BURST clears.
  always_comb begin
    addr_next       = addr;
    beats_left_next = beats_left;
    datab_next      = datab;
    valid_next      = valid;
    last_next       = last;
    busy            = (state == BURST);
    case (state)
      IDLE: begin
        if (cs && read_en) begin
          addr_next       = addrb;
          beats_left_next = burst_len;
          datab_next      = rom_word(addrb);
          valid_next      = 1'b1;
          last_next       = (burst_len == 4'd0);
        end else begin
          datab_next = '0;
          valid_next = 1'b0;
          last_next  = 1'b0;
        end
      end
      BURST: begin
        if (!cs || (ready && (beats_left == 4'd0))) begin
          datab_next = '0;
          valid_next = 1'b0;
          last_next  = 1'b0;
        end else if (ready) begin
          addr_next       = addr + ADDR_W'(1);
          beats_left_next = beats_left - 4'd1;
          datab_next      = rom_word(addr + ADDR_W'(1));
          valid_next      = 1'b1;
          last_next       = (beats_left == 4'd1);
        end
      end
      default: begin
        datab_next = '0;
        valid_next = 1'b0;
        last_next  = 1'b0;
      end
    endcase
  end

  // Datapath registers hold the presented word and the burst position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      beats_left <= '0;
      datab      <= '0;
      valid      <= 1'b0;
      last       <= 1'b0;
    end else begin
      addr       <= addr_next;
      beats_left <= beats_left_next;
      datab      <= datab_next;
      valid      <= valid_next;
      last       <= last_next;
    end
  end

`ifdef ROM_PARITY_EN
  // Parity is registered together with datab, so a cleared datab also gives zero parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_par <= 1'b0;
    end else begin
      data_par <= ^datab_next;
    end
  end
`endif

endmodule

// File: tb/tb_burst_rom_reader.sv
// tb_burst_rom_reader: directed bench for burst_rom_reader (DATA_W=8, ADDR_W=4).
// Expected words are hand-computed from (10*a + 18) mod 256.
module tb_burst_rom_reader;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       read_en;
  logic [3:0] addrb;
  logic [3:0] burst_len;
  logic       ready;
  logic [7:0] datab;
  logic       valid;
  logic       last;
  logic       busy;
`ifdef ROM_PARITY_EN
  logic       data_par;
`endif

  int tests_run;
  int tests_failed;

  burst_rom_reader #(
    .DATA_W(8),
    .ADDR_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .read_en  (read_en),
    .addrb    (addrb),
    .burst_len(burst_len),
    .ready    (ready),
    .datab    (datab),
    .valid    (valid),
    .last     (last),
    .busy     (busy)
`ifdef ROM_PARITY_EN
    ,
    .data_par (data_par)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic c, input logic re, input logic [3:0] a,
                               input logic [3:0] len, input logic rdy);
    cs        = c;
    read_en   = re;
    addrb     = a;
    burst_len = len;
    ready     = rdy;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " valid"}, {31'd0, valid}, 32'd0);
    checkOutput({tag, " datab"}, {24'd0, datab}, 32'd0);
    checkOutput({tag, " last"},  {31'd0, last},  32'd0);
    checkOutput({tag, " busy"},  {31'd0, busy},  32'd0);
  endtask

  task automatic checkBeat(input string tag, input logic [7:0] word, input logic is_last);
    checkOutput({tag, " valid"}, {31'd0, valid}, 32'd1);
    checkOutput({tag, " datab"}, {24'd0, datab}, {24'd0, word});
    checkOutput({tag, " last"},  {31'd0, last},  {31'd0, is_last});
    checkOutput({tag, " busy"},  {31'd0, busy},  32'd1);
  endtask

  initial begin
    logic [7:0] wrap_words [4];
    logic [7:0] stall_word;
    wrap_words[0] = 8'd158;
    wrap_words[1] = 8'd168;
    wrap_words[2] = 8'd18;
    wrap_words[3] = 8'd28;
    stall_word    = 8'd28;
    tests_run    = 0;
    tests_failed = 0;

    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    repeat (2) step();
    checkIdle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkIdle("post-reset");

    // Single read from address 3
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    checkBeat("single", 8'd48, 1'b1);
`ifdef ROM_PARITY_EN
    checkOutput("single par", {31'd0, data_par}, 32'd0);
`endif
    step();
    checkIdle("single end");

    // Wrap burst from 14; read_en/addrb are changed mid-burst and must be ignored
    applyStimulus(1'b1, 1'b1, 4'd14, 4'd3, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkBeat($sformatf("wrap%0d", i), wrap_words[i], (i == 3));
      if (i == 1) applyStimulus(1'b1, 1'b1, 4'd7, 4'd9, 1'b1);
      if (i == 2) applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
      step();
    end
    checkIdle("wrap end");

    // Backpressure on beat 2
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd2, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    checkBeat("bp beat1", 8'd18, 1'b0);
    step();
    checkBeat("bp beat2", stall_word, 1'b0);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkBeat($sformatf("bp stall%0d", i), stall_word, 1'b0);
    end
    ready = 1'b1;
    step();
    checkBeat("bp beat3", 8'd38, 1'b1);
    step();
    checkIdle("bp end");

    // Abort: burst of 8 from 5, cs dropped after beat 2 while ready=1
    applyStimulus(1'b1, 1'b1, 4'd5, 4'd7, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    checkBeat("abort beat1", 8'd68, 1'b0);
    step();
    checkBeat("abort beat2", 8'd78, 1'b0);
    cs = 1'b0;
    step();
    checkIdle("abort");
    applyStimulus(1'b1, 1'b1, 4'd2, 4'd1, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    checkBeat("restart beat1", 8'd38, 1'b0);
    step();
    checkBeat("restart beat2", 8'd48, 1'b1);
    step();
    checkIdle("restart end");

    // Back-to-back requests with read_en held high leave a one-cycle gap
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd0, 1'b1);
    step();
    checkBeat("b2b first", 8'd48, 1'b1);
    step();
    checkIdle("b2b gap");
    step();
    checkBeat("b2b second", 8'd48, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    step();
    checkIdle("b2b end");

    // Reset pulsed during beat 3
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd5, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    step();
    step();
    checkBeat("rst beat3", 8'd38, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'd1, 4'd0, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    checkBeat("after reset", 8'd28, 1'b1);
`ifdef ROM_PARITY_EN
    checkOutput("after reset par", {31'd0, data_par}, 32'd1);
`endif
    step();
    checkIdle("after reset end");
`ifdef ROM_PARITY_EN
    checkOutput("idle par", {31'd0, data_par}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
